// File: rtl/stack_frame_engine.sv
// stack_frame_engine: stack sequencer executing PUSH_W/POP_W/CALL/INT/RET/RTI against a data-memory stack port
// Ports: clk, rst (sync, active-high); cmd_valid/cmd in, busy/done out;
//   pc_in/ccr_in/word_in push operands latched at accept;
//   mem_addr/mem_wdata/mem_we/mem_re out, mem_rdata in (read data one cycle after mem_re);
//   pc_out/ccr_out/word_out popped values with 1-cycle *_valid pulses; sp = next free slot.
// Option: define STACK_GUARD_EN to add err and reject pushes/pops that would overflow/underflow.
module stack_frame_engine #(
    parameter int AW           = 11,
    parameter int STACK_TOP    = 2**AW-1,
    parameter int STACK_BOTTOM = 0,
    parameter int CCR_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      pc_in,
    input  logic [CCR_W-1:0] ccr_in,
    input  logic [15:0]      word_in,
    output logic [AW-1:0]    mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [15:0]      mem_rdata,
    output logic [31:0]      pc_out,
    output logic             pc_out_valid,
    output logic [CCR_W-1:0] ccr_out,
    output logic             ccr_out_valid,
    output logic [15:0]      word_out,
    output logic             word_out_valid,
    output logic [AW-1:0]    sp
`ifdef STACK_GUARD_EN
    ,
    output logic             err
`endif
);
    typedef enum logic [2:0] {IDLE, PUSH, POP_RD, POP_LAST, DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d, n_q, n_d, n_new;
    logic [2:0]       cmd_q, cmd_d;
    logic [47:0]      data_q, data_d, cap;
    logic [AW-1:0]    sp_q, sp_d, mem_addr_q, mem_addr_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d, word_out_q, word_out_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic [CCR_W-1:0] ccr_out_q, ccr_out_d;
    logic             mem_we_q, mem_we_d, mem_re_q, mem_re_d, busy_q, busy_d, done_q, done_d;
    logic             pc_v_q, pc_v_d, ccr_v_q, ccr_v_d, word_v_q, word_v_d;
    logic             accept, is_push, last, reject;

    assign n_new   = (cmd == 3'd1 || cmd == 3'd2) ? 2'd1 : (cmd == 3'd4 || cmd == 3'd6) ? 2'd3 : 2'd2;
    assign is_push = cmd == 3'd1 || cmd == 3'd3 || cmd == 3'd4;
    assign accept  = cmd_valid && !busy_q && cmd != 3'd0 && cmd != 3'd7;
    assign last    = cnt_q == n_q - 2'd1;
    // popped words shift in from the top, so after N reads the last word sits in [47:32]
    assign cap     = {mem_rdata, data_q[47:16]};

`ifdef STACK_GUARD_EN
    logic [AW+1:0] free_slots, used_slots;
    logic          err_q, err_d;
    assign free_slots = {2'b00, sp_q} - (AW+2)'(STACK_BOTTOM) + (AW+2)'(1);
    assign used_slots = (AW+2)'(STACK_TOP) - {2'b00, sp_q};
    assign reject     = is_push ? free_slots < (AW+2)'(n_new) : used_slots < (AW+2)'(n_new);
    assign err_d      = accept && reject;
    assign err        = err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 2'd1;
        cmd_d      = cmd_q;
        n_d        = n_q;
        data_d     = data_q;
        sp_d       = sp_q;
        pc_out_d   = pc_out_q;
        ccr_out_d  = ccr_out_q;
        word_out_d = word_out_q;
        pc_v_d     = 1'b0;
        ccr_v_d    = 1'b0;
        word_v_d   = 1'b0;
        case (state_q)
            PUSH: begin
                sp_d    = sp_q - AW'(1);
                data_d  = {data_q[31:0], 16'h0000};
                state_d = last ? DONE : PUSH;
            end
            POP_RD: begin
                sp_d    = sp_q + AW'(1);
                data_d  = cnt_q == 2'd0 ? data_q : cap;
                state_d = last ? POP_LAST : POP_RD;
            end
            POP_LAST: begin
                state_d    = DONE;
                pc_out_d   = cmd_q == 3'd2 ? pc_out_q : cap[47:16];
                ccr_out_d  = cmd_q == 3'd6 ? cap[CCR_W-1:0] : ccr_out_q;
                word_out_d = cmd_q == 3'd2 ? cap[47:32] : word_out_q;
                pc_v_d     = cmd_q != 3'd2;
                ccr_v_d    = cmd_q == 3'd6;
                word_v_d   = cmd_q == 3'd2;
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    cnt_d   = 2'd0;
                    cmd_d   = cmd;
                    n_d     = n_new;
                    data_d  = cmd == 3'd1 ? {word_in, 32'h0} : {pc_in, 16'(ccr_in)};
                    state_d = reject ? DONE : is_push ? PUSH : POP_RD;
                end
            end
        endcase
        busy_d      = state_d == PUSH || state_d == POP_RD || state_d == POP_LAST;
        done_d      = state_d == DONE;
        mem_we_d    = state_d == PUSH;
        mem_re_d    = state_d == POP_RD;
        mem_addr_d  = mem_we_d ? sp_d : mem_re_d ? sp_d + AW'(1) : mem_addr_q;
        mem_wdata_d = mem_we_d ? data_d[47:32] : mem_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            cmd_q       <= 3'd0;
            n_q         <= 2'd0;
            data_q      <= 48'h0;
            sp_q        <= AW'(STACK_TOP);
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pc_out_q    <= 32'h0;
            ccr_out_q   <= '0;
            word_out_q  <= 16'h0;
            pc_v_q      <= 1'b0;
            ccr_v_q     <= 1'b0;
            word_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            n_q         <= n_d;
            data_q      <= data_d;
            sp_q        <= sp_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pc_out_q    <= pc_out_d;
            ccr_out_q   <= ccr_out_d;
            word_out_q  <= word_out_d;
            pc_v_q      <= pc_v_d;
            ccr_v_q     <= ccr_v_d;
            word_v_q    <= word_v_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_we         = mem_we_q;
    assign mem_re         = mem_re_q;
    assign pc_out         = pc_out_q;
    assign pc_out_valid   = pc_v_q;
    assign ccr_out        = ccr_out_q;
    assign ccr_out_valid  = ccr_v_q;
    assign word_out       = word_out_q;
    assign word_out_valid = word_v_q;
    assign sp             = sp_q;
endmodule

// File: tb/tb_stack_frame_engine.sv
// tb_stack_frame_engine: directed and random frame sequences checked against a stack-memory model
module tb_stack_frame_engine;
    localparam int AW  = 11;
    localparam int TOP = 2**AW-1;
    localparam int SZ  = 2**AW;

    logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [31:0]   pc_in = 32'h0;
    logic [3:0]    ccr_in = 4'h0;
    logic [15:0]   word_in = 16'h0;
    logic          busy, done, mem_we, mem_re, pc_out_valid, ccr_out_valid, word_out_valid;
    logic [AW-1:0] mem_addr, sp;
    logic [15:0]   mem_wdata, mem_rdata, word_out;
    logic [31:0]   pc_out;
    logic [3:0]    ccr_out;
`ifdef STACK_GUARD_EN
    logic          err;
`endif

    logic [15:0] mem [SZ] = '{default: 16'h0};
    logic [15:0] ref_mem [SZ] = '{default: 16'h0};
    int          sp_m = TOP;
    logic [31:0] pc_m = 32'h0;
    logic [3:0]  ccr_m = 4'h0;
    logic [15:0] word_m = 16'h0;
    int          tests = 0, fails = 0;

    stack_frame_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .busy(busy), .done(done),
        .pc_in(pc_in), .ccr_in(ccr_in), .word_in(word_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .pc_out(pc_out), .pc_out_valid(pc_out_valid), .ccr_out(ccr_out), .ccr_out_valid(ccr_out_valid),
        .word_out(word_out), .word_out_valid(word_out_valid), .sp(sp)
`ifdef STACK_GUARD_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        sp_m = TOP;
        pc_m = 32'h0;
        ccr_m = 4'h0;
        word_m = 16'h0;
        @(negedge clk);
        chk("rst_sp", 32'(sp), TOP);
        chk("rst_ctl", {busy, done, mem_we, mem_re, pc_out_valid, ccr_out_valid, word_out_valid}, 0);
        chk("rst_outs", {pc_out ^ {ccr_out, 28'h0}, 16'h0} | {16'h0, word_out}, 0);
        chk("rst_mem_port", {5'h0, mem_addr, mem_wdata}, 0);
    endtask

    task automatic nop_step();
        cmd = $urandom_range(0, 1) == 0 ? 3'd0 : 3'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("nop_ctl", {busy, done, mem_we, mem_re, pc_out_valid, ccr_out_valid, word_out_valid}, 0);
        chk("nop_sp", 32'(sp), sp_m);
    endtask

    // Starts a command in the current cycle T and checks every cycle through its done cycle.
    task automatic run_op(input logic [2:0] c, input logic [31:0] p, input logic [3:0] f,
                          input logic [15:0] w, input bit noise);
        int n, nb, nd, a, sp0;
        bit push, rej;
        logic [15:0] wd [3];
        logic [6:0] ctl;
        n = (c == 1 || c == 2) ? 1 : (c == 4 || c == 6) ? 3 : 2;
        push = c == 1 || c == 3 || c == 4;
`ifdef STACK_GUARD_EN
        rej = push ? (sp_m + 1 < n) : (TOP - sp_m < n);
`else
        rej = 1'b0;
`endif
        nb = rej ? 0 : push ? n : n + 1;
        nd = nb + 1;
        sp0 = sp_m;
        if (c == 1) begin
            wd[0] = w; wd[1] = 16'h0; wd[2] = 16'h0;
        end else begin
            wd[0] = p[31:16]; wd[1] = p[15:0]; wd[2] = {12'h0, f};
        end
        if (!push) for (int j = 0; j < 3; j++) wd[j] = ref_mem[(sp0 + 1 + j) % SZ];
        cmd = c; pc_in = p; ccr_in = f; word_in = w; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= nd; k++) begin
            @(negedge clk);
            a = push ? (sp0 - (k - 1) + SZ) % SZ : (sp0 + k) % SZ;
            ctl = {k <= nb, k == nd, push && !rej && k <= n, !push && !rej && k <= n,
                   k == nd && !rej && (c == 5 || c == 6), k == nd && !rej && c == 6, k == nd && !rej && c == 2};
            chk($sformatf("ctl cmd%0d cyc%0d", c, k),
                {busy, done, mem_we, mem_re, pc_out_valid, ccr_out_valid, word_out_valid}, ctl);
            if (ctl[4] || ctl[3]) chk($sformatf("addr cmd%0d cyc%0d", c, k), 32'(mem_addr), a);
            if (ctl[4]) begin
                chk($sformatf("wdata cmd%0d cyc%0d", c, k), mem_wdata, wd[k-1]);
                ref_mem[a] = wd[k-1];
            end
`ifdef STACK_GUARD_EN
            chk($sformatf("err cmd%0d cyc%0d", c, k), err, k == 1 && rej);
`endif
            if (k == nd) begin
                cmd_valid = 1'b0;
                if (!rej) begin
                    sp_m = push ? (sp0 - n + SZ) % SZ : (sp0 + n) % SZ;
                    if (c == 5) pc_m = {wd[1], wd[0]};
                    if (c == 6) begin ccr_m = wd[0][3:0]; pc_m = {wd[2], wd[1]}; end
                    if (c == 2) word_m = wd[0];
                    if (push) for (int j = 0; j < n; j++)
                        chk($sformatf("mem cmd%0d slot%0d", c, j), mem[(sp0 - j + SZ) % SZ], ref_mem[(sp0 - j + SZ) % SZ]);
                end
                chk($sformatf("sp cmd%0d", c), 32'(sp), sp_m);
                chk($sformatf("pc_out cmd%0d", c), pc_out, pc_m);
                chk($sformatf("ccr_out cmd%0d", c), 32'(ccr_out), 32'(ccr_m));
                chk($sformatf("word_out cmd%0d", c), 32'(word_out), 32'(word_m));
            end else begin
                cmd_valid = noise;
                cmd = 3'($urandom_range(0, 7));
                pc_in = $urandom;
                ccr_in = 4'($urandom);
                word_in = 16'($urandom);
            end
        end
    endtask

    initial begin
        do_reset();
        run_op(3'd3, 32'h0001_2345, 4'h0, 16'h0, 1'b0);
        chk("call_hi", 32'(mem[TOP]), 32'h0001);
        chk("call_lo", 32'(mem[TOP-1]), 32'h2345);
        chk("call_sp", 32'(sp), 32'h7FD);

        do_reset();
        run_op(3'd4, 32'hABCD_0010, 4'h5, 16'h0, 1'b0);
        chk("int_ccr_slot", 32'(mem[TOP-2]), 32'h0005);
        run_op(3'd6, 32'h0, 4'h0, 16'h0, 1'b0);
        chk("rti_pc", pc_out, 32'hABCD_0010);
        chk("rti_ccr", 32'(ccr_out), 32'h5);
        chk("rti_sp", 32'(sp), TOP);

        run_op(3'd1, 32'h0, 4'h0, 16'hBEEF, 1'b1);
        run_op(3'd2, 32'h0, 4'h0, 16'h0, 1'b1);
        chk("popw_word", 32'(word_out), 32'hBEEF);

        do_reset();
        run_op(3'd5, 32'h0, 4'h0, 16'h0, 1'b0);
`ifdef STACK_GUARD_EN
        chk("ret_empty_sp", 32'(sp), TOP);
`else
        chk("ret_empty_sp", 32'(sp), 32'h001);
`endif

        do_reset();
        cmd = 3'd4; pc_in = 32'h1234_5678; ccr_in = 4'h9; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_mem[TOP] = 16'h1234;
        ref_mem[TOP-1] = 16'h5678;
        sp_m = TOP; pc_m = 32'h0; ccr_m = 4'h0; word_m = 16'h0;
        @(negedge clk);
        chk("abort_ctl", {busy, done, mem_we, mem_re, pc_out_valid, ccr_out_valid, word_out_valid}, 0);
        chk("abort_sp", 32'(sp), TOP);
        @(negedge clk);
        chk("abort_ctl2", {busy, done, mem_we, mem_re, pc_out_valid, ccr_out_valid, word_out_valid}, 0);
        chk("abort_mem", 32'(mem[TOP-1]), 32'h5678);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) nop_step();
            else run_op(3'($urandom_range(1, 6)), $urandom, 4'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
